mipi_line_packer: RTL and testbench
===================================

MIPI_LINE_PACKER -- requirements
Module: mipi_line_packer

Interface
REQ-001 Parameter WORDS_PER_LINE, default 4, meaning payload words per packet; legal range 1..255.
REQ-002 Parameter DATA_TYPE, default 8'h2A, meaning data-type byte placed in the packet header.
REQ-003 Parameter FIFO_DEPTH, default 8, meaning input buffer depth in words; power of two, at least 2.
REQ-004 Port list (one clock; reset is asynchronous and active-low), one per line:
- clk  input  1  sole clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  16  stitched 16-bit word from the upstream stitcher.
- in_valid  input  1  single-cycle qualifier for in_data; there is no backpressure to upstream.
- out_data  output  16  packet word (header, payload or CRC).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_sop  output  1  first word of a packet (the header).
- out_eop  output  1  last word of a packet.
- overflow  output  1  sticky flag: an input word was dropped.

Function
REQ-005 Input words SHALL be written to an internal FIFO on each cycle where in_valid=1 and the FIFO is not full.
REQ-006 Full SHALL be evaluated before any same-cycle pop; when in_valid=1 and full, the word is dropped and overflow is set to 1 until reset.
REQ-007 A transfer SHALL occur when out_valid=1 and out_ready=1; while out_ready=0, out_data, out_sop and out_eop hold stable.
REQ-008 The state machine SHALL use states IDLE, HDR, PAYLOAD and CRC.
REQ-009 IDLE -> HDR on the cycle after the FIFO becomes non-empty. The minimum in_valid-to-out_valid latency is 2 cycles (write at edge t, HDR entered at edge t+1).
REQ-010 In HDR, out_valid=1, out_sop=1 and out_data={DATA_TYPE, WORDS_PER_LINE[7:0]}. A transfer moves to PAYLOAD and loads the CRC register with 16'hFFFF.
REQ-011 In PAYLOAD, out_valid SHALL equal FIFO non-empty, with out_data equal to the FIFO head.
- Each transfer pops one word, increments the payload counter and updates the CRC.
- An empty FIFO mid-packet produces bubbles and is not an error.
REQ-012 On transfer of payload word WORDS_PER_LINE, the block SHALL go to CRC and clear the payload counter.
REQ-013 In CRC, out_valid=1, out_eop=1 and out_data equals the CRC register. A transfer returns to IDLE, or goes directly to HDR if the FIFO is non-empty.
REQ-014 CRC SHALL be CRC-16/CCITT-FALSE (polynomial 0x1021, init 0xFFFF, no reflection, no final XOR).
- Computed over payload words, MSB first, 16 bits per cycle.
- Computed combinationally from the current register and the head word.
REQ-015 Simultaneous push and pop SHALL both take effect; the FIFO occupancy is then unchanged.
REQ-016 The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH, so full and empty are distinguishable.

Reset
REQ-017 When rst_n=0, the block SHALL asynchronously force:
- state to IDLE;
- FIFO pointers, payload counter and overflow to 0;
- CRC register to 16'hFFFF;
- out_valid, out_sop and out_eop to 0, and out_data to 16'h0000.
REQ-018 A reset mid-packet SHALL discard the partial packet; no out_eop is emitted for it. Reset release is synchronised to clk inside the block.

Configuration
REQ-019 Macro MIPI_LINE_PACKER_CRC_EN, when defined, SHALL compile in the CRC state, the CRC register and the CRC footer word.
REQ-020 When MIPI_LINE_PACKER_CRC_EN is undefined, the CRC logic SHALL be absent.
- out_eop is asserted on the last payload word.
- A transfer of that word leaves PAYLOAD directly for IDLE or HDR.
- Packet length is WORDS_PER_LINE+1 words.

Structure
REQ-021 The shared package mipi_pkg SHALL hold:
- the state enum type (IDLE/HDR/PAYLOAD/CRC);
- constants CRC16_POLY=16'h1021 and CRC16_INIT=16'hFFFF;
- the default DATA_TYPE constant 8'h2A.
REQ-022 The FIFO SHALL be the sub-module mipi_sync_fifo (parameter DEPTH, 16-bit width, push/pop/full/empty); the CRC step is a package function.

Verification
REQ-023 With CRC_EN defined and defaults, push 0x1111, 0x2222, 0x3333, 0x4444 with out_ready=1. Required output: 0x2A04 (sop), then the four words in order, then the CRC (eop) matching the bench model. The model is validated by check value 0x29B1 for ASCII "123456789".
REQ-024 Hold out_ready=0 for 5 cycles during PAYLOAD -> out_data and out_valid stay stable, no word is lost, and the sequence resumes unchanged.
REQ-025 Push 10 words back-to-back with out_ready=0 (FIFO_DEPTH=8) -> words 9 and 10 are dropped, overflow=1 stays set, and the first packet carries words 1-4.
REQ-026 Assert rst_n=0 after header plus 2 payload words -> all outputs are 0 asynchronously; after release with no input, out_valid stays 0.
REQ-027 With CRC_EN undefined, push 4 words -> a 5-word packet is emitted, out_eop is on word 4, and the next header may follow on the very next cycle.
REQ-028 Push 8 words spaced every 3 cycles -> two complete packets, payload bubbles allowed, no overflow, and pointers wrap correctly.

Source files
------------

// File: rtl/mipi_pkg.sv
// Shared types, CRC constants and the CRC-16/CCITT-FALSE word step for the
// MIPI line packer.
package mipi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CRC
  } state_t;

  localparam logic [15:0] CRC16_POLY        = 16'h1021;
  localparam logic [15:0] CRC16_INIT        = 16'hFFFF;
  localparam logic [7:0]  DEFAULT_DATA_TYPE = 8'h2A;

  // One 16-bit word folded into the CRC, MSB first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [15:0] data);
    logic [15:0] c;
    logic [15:0] d;
    c = crc;
    d = data;
    for (int unsigned i = 0; i < 16; i++) begin
      if (c[15] ^ d[15]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
      else               c = {c[14:0], 1'b0};
      d = {d[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/mipi_sync_fifo.sv
// Synchronous 16-bit FIFO with extra-MSB pointers so full and empty differ;
// the head word is presented combinationally.
module mipi_sync_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  logic [15:0] i_data,
  input  logic        i_pop,
  output logic [15:0] o_head,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_level
);

  logic [15:0] r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_wr_en;
  logic        w_rd_en;

  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_empty = (r_wr == r_rd);
  assign o_level = r_wr - r_rd;
  assign o_head  = r_mem[r_rd[AW-1:0]];

  // Full is judged on the pre-pop occupancy, so a push into a full FIFO
  // is dropped even when a pop happens in the same cycle.
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + (AW+1)'(1);
      if (w_rd_en) r_rd <= r_rd + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mipi_line_packer.sv
// Wraps buffered 16-bit line words into header/payload[/CRC] packets.
// Define MIPI_LINE_PACKER_CRC_EN to append a CRC-16/CCITT-FALSE footer word.
module mipi_line_packer
  import mipi_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter logic [7:0]  DATA_TYPE      = DEFAULT_DATA_TYPE,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic        overflow
);

  localparam int unsigned LW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  LP_WPL  = 8'(WORDS_PER_LINE);
  localparam logic [7:0]  LP_LAST = 8'(WORDS_PER_LINE - 1);

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  state_t        r_state;
  logic [7:0]    r_cnt;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_xfer;
  logic          w_last;
  logic [15:0]   w_head;
  logic [LW-1:0] w_level;
`ifdef MIPI_LINE_PACKER_CRC_EN
  logic [15:0]   r_crc;
`endif

  // Assertion is immediate; release is retimed to clk through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  mipi_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_xfer = out_valid && out_ready;
  assign w_pop  = (r_state == PAYLOAD) && w_xfer;
  assign w_last = (r_cnt == LP_LAST);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
`ifdef MIPI_LINE_PACKER_CRC_EN
      r_crc   <= CRC16_INIT;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) r_state <= HDR;
        end
        HDR: begin
          if (w_xfer) begin
            r_state <= PAYLOAD;
`ifdef MIPI_LINE_PACKER_CRC_EN
            r_crc   <= CRC16_INIT;
`endif
          end
        end
        PAYLOAD: begin
          if (w_xfer) begin
`ifdef MIPI_LINE_PACKER_CRC_EN
            r_crc <= crc16_step(r_crc, w_head);
`endif
            if (w_last) begin
              r_cnt <= '0;
`ifdef MIPI_LINE_PACKER_CRC_EN
              r_state <= CRC;
`else
              // Level still counts the word popped this cycle.
              r_state <= (w_level > LW'(1)) ? HDR : IDLE;
`endif
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        CRC: begin
`ifdef MIPI_LINE_PACKER_CRC_EN
          if (w_xfer) r_state <= (w_level != '0) ? HDR : IDLE;
`else
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)               r_overflow <= 1'b0;
    else if (in_valid && w_full) r_overflow <= 1'b1;
  end
  assign overflow = r_overflow;

  always_comb begin
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    case (r_state)
      HDR: begin
        out_valid = 1'b1;
        out_sop   = 1'b1;
        out_data  = {DATA_TYPE, LP_WPL};
      end
      PAYLOAD: begin
        out_valid = !w_empty;
        out_data  = w_head;
`ifndef MIPI_LINE_PACKER_CRC_EN
        out_eop   = w_last && !w_empty;
`endif
      end
      CRC: begin
`ifdef MIPI_LINE_PACKER_CRC_EN
        out_valid = 1'b1;
        out_eop   = 1'b1;
        out_data  = r_crc;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mipi_line_packer.sv
// Directed bench for mipi_line_packer with default parameters; follows the
// MIPI_LINE_PACKER_CRC_EN define of the build.
module tb_mipi_line_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        overflow;

  int checks = 0;
  int errors = 0;

`ifdef MIPI_LINE_PACKER_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  localparam int PKT_LEN = CRC_ON ? 6 : 5;

  always #5 clk = ~clk;

  mipi_line_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .overflow  (overflow)
  );

  logic [15:0] stim_q[$];
  logic [15:0] got_d[$];
  bit          got_sop[$];
  bit          got_eop[$];
  int          got_cyc[$];
  logic [15:0] exp_d[$];
  bit          exp_sop[$];
  bit          exp_eop[$];
  bit          log_valid[256];
  logic [15:0] log_data[256];

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic add_packet(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    logic [15:0] w[4];
    logic [15:0] crc;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    crc = 16'hFFFF;
    exp_d.push_back(16'h2A04); exp_sop.push_back(1'b1); exp_eop.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      crc = crc_byte(crc_byte(crc, w[i][15:8]), w[i][7:0]);
      exp_d.push_back(w[i]);
      exp_sop.push_back(1'b0);
      exp_eop.push_back(!CRC_ON && i == 3);
    end
    if (CRC_ON) begin
      exp_d.push_back(crc); exp_sop.push_back(1'b0); exp_eop.push_back(1'b1);
    end
  endtask

  task automatic clear_exp();
    exp_d.delete(); exp_sop.delete(); exp_eop.delete();
  endtask

  // Steps n cycles: push from stim_q every gap cycles, stall ready in
  // [stall_lo, stall_hi), and record every transfer and per-cycle outputs.
  task automatic drive(input int n, input int gap, input int stall_lo, input int stall_hi);
    got_d.delete(); got_sop.delete(); got_eop.delete(); got_cyc.delete();
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= stall_lo && c < stall_hi);
      if (stim_q.size() > 0 && (c % gap) == 0) begin
        in_valid = 1'b1;
        in_data  = stim_q.pop_front();
      end else begin
        in_valid = 1'b0;
      end
      log_valid[c] = out_valid;
      log_data[c]  = out_data;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_sop.push_back(out_sop);
        got_eop.push_back(out_eop);
        got_cyc.push_back(c);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_crc_model();
    logic [15:0] crc;
    crc = 16'hFFFF;
    for (int i = 0; i < 9; i++) crc = crc_byte(crc, 8'(8'h31 + i));
    checks++;
    if (crc !== 16'h29B1) begin
      errors++;
      $display("FAIL crc_model got %h exp 29b1", crc);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 ||
        out_data !== 16'h0000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v%b s%b e%b d%h o%b exp all 0",
               out_valid, out_sop, out_eop, out_data, overflow);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle got out_valid %b exp 0", out_valid);
      end
    end
  endtask

  task automatic test_basic();
    clear_exp();
    add_packet(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    stim_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    drive(20, 1, -1, -1);
    checks++;
    if (log_valid[1] !== 1'b0 || log_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency got valid@1=%b valid@2=%b exp 0,1", log_valid[1], log_valid[2]);
    end
    checks++;
    if (got_d.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL basic_len got %0d exp %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++;
        $display("FAIL basic_word%0d got %h sop%b eop%b exp %h sop%b eop%b",
                 i, got_d[i], got_sop[i], got_eop[i], exp_d[i], exp_sop[i], exp_eop[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_exp();
    add_packet(16'hB001, 16'hB002, 16'hB003, 16'hB004);
    stim_q = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};
    drive(40, 1, 4, 9);
    for (int c = 4; c < 9; c++) begin
      checks++;
      if (log_valid[c] !== 1'b1 || log_data[c] !== 16'hB002) begin
        errors++;
        $display("FAIL stall_hold%0d got v%b d%h exp v1 db002", c, log_valid[c], log_data[c]);
      end
    end
    checks++;
    if (got_d.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL stall_len got %0d exp %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++;
        $display("FAIL stall_word%0d got %h sop%b eop%b exp %h sop%b eop%b",
                 i, got_d[i], got_sop[i], got_eop[i], exp_d[i], exp_sop[i], exp_eop[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_exp();
    add_packet(16'hD001, 16'hD002, 16'hD003, 16'hD004);
    add_packet(16'hD005, 16'hD006, 16'hD007, 16'hD008);
    stim_q = '{16'hD001, 16'hD002, 16'hD003, 16'hD004,
               16'hD005, 16'hD006, 16'hD007, 16'hD008};
    drive(40, 1, -1, -1);
    checks++;
    if (got_d.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL b2b_len got %0d exp %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++;
        $display("FAIL b2b_word%0d got %h sop%b eop%b exp %h sop%b eop%b",
                 i, got_d[i], got_sop[i], got_eop[i], exp_d[i], exp_sop[i], exp_eop[i]);
      end
    end
    if (got_cyc.size() > PKT_LEN) begin
      checks++;
      if (got_cyc[PKT_LEN] !== got_cyc[PKT_LEN-1] + 1) begin
        errors++;
        $display("FAIL b2b_gap got sop2 at %0d exp %0d", got_cyc[PKT_LEN], got_cyc[PKT_LEN-1] + 1);
      end
    end
  endtask

  task automatic test_spaced();
    clear_exp();
    add_packet(16'hE001, 16'hE002, 16'hE003, 16'hE004);
    add_packet(16'hE005, 16'hE006, 16'hE007, 16'hE008);
    stim_q = '{16'hE001, 16'hE002, 16'hE003, 16'hE004,
               16'hE005, 16'hE006, 16'hE007, 16'hE008};
    drive(60, 3, -1, -1);
    checks++;
    if (got_d.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL spaced_len got %0d exp %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++;
        $display("FAIL spaced_word%0d got %h sop%b eop%b exp %h sop%b eop%b",
                 i, got_d[i], got_sop[i], got_eop[i], exp_d[i], exp_sop[i], exp_eop[i]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL spaced_overflow got %b exp 0", overflow);
    end
  endtask

  task automatic test_overflow();
    clear_exp();
    add_packet(16'hC001, 16'hC002, 16'hC003, 16'hC004);
    add_packet(16'hC005, 16'hC006, 16'hC007, 16'hC008);
    stim_q = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005,
               16'hC006, 16'hC007, 16'hC008, 16'hC009, 16'hC00A};
    drive(70, 1, 0, 15);
    checks++;
    if (got_d.size() !== exp_d.size()) begin
      errors++;
      $display("FAIL ovf_len got %0d exp %0d", got_d.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_sop[i] !== exp_sop[i] || got_eop[i] !== exp_eop[i]) begin
        errors++;
        $display("FAIL ovf_word%0d got %h sop%b eop%b exp %h sop%b eop%b",
                 i, got_d[i], got_sop[i], got_eop[i], exp_d[i], exp_sop[i], exp_eop[i]);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b exp 1", overflow);
    end
  endtask

  task automatic test_reset_midpacket();
    bit seen;
    stim_q = '{16'hF001, 16'hF002, 16'hF003, 16'hF004};
    drive(5, 1, -1, -1);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hF003) begin
      errors++;
      $display("FAIL mid_before got v%b d%h exp v1 df003", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 ||
        out_data !== 16'h0000 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got v%b s%b e%b d%h o%b exp all 0",
               out_valid, out_sop, out_eop, out_data, overflow);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || out_eop !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_after got activity after reset exp out_valid 0");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_crc_model();
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_spaced();
    test_overflow();
    test_reset_midpacket();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
